// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the MEM/WB register and the write-back stage.
package riscv_pkg;

    // Write-back result select encoding, shared with the MEM/WB pipeline register.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    localparam int REG_ADDR_W = 5;
    localparam int A0_IDX     = 10;
    localparam int PC_INC     = 4;

endpackage

// File: rtl/wb_regfile_reg_file.sv
// Architectural integer register file: one write port, two raw read ports,
// synchronous clear and a direct tap on x10 (a0).
module reg_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int AW         = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr1,
    input  logic [AW-1:0]         rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic [DATA_WIDTH-1:0] a0
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    // Clear every entry on reset; otherwise commit the single write, never to x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Raw storage reads; x0 masking and bypass are handled by the wrapper.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        a0       = regs[A0_IDX];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the retiring result, commits it to the register
// file and serves the decode read ports with same-cycle write-through bypass.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wb_rd_in,
    input  logic [DATA_WIDTH-1:0] wb_pc_in,
    input  logic [DATA_WIDTH-1:0] wb_alu_res_in,
    input  logic [DATA_WIDTH-1:0] wb_sign_immediate_in,
    input  logic [DATA_WIDTH-1:0] wb_data_mem_res_in,
    input  logic                  wb_reg_write_en_in,
    input  logic [1:0]            wb_write_back_mux_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr_in,
    input  logic [REG_ADDR_W-1:0] rs2_addr_in,
    output logic [DATA_WIDTH-1:0] rs1_data_out,
    output logic [DATA_WIDTH-1:0] rs2_data_out,
    output logic [DATA_WIDTH-1:0] wb_result_out,
    output logic [DATA_WIDTH-1:0] a0_out
);

    localparam int AW = $clog2(REG_COUNT);

    wb_sel_t               wb_sel;
    logic                  commit;
    logic [DATA_WIDTH-1:0] raw1;
    logic [DATA_WIDTH-1:0] raw2;

    assign wb_sel = wb_sel_t'(wb_write_back_mux_in);

    // A write only lands when enabled, not aimed at x0 and not swallowed by reset;
    // the same condition gates the bypass so reads never see a discarded write.
    assign commit = wb_reg_write_en_in && (wb_rd_in != '0) && !rst;

    // Result select; the link address wraps naturally at the datapath width.
    always_comb begin
        wb_result_out = wb_alu_res_in;
        case (wb_sel)
            WB_ALU: wb_result_out = wb_alu_res_in;
            WB_MEM: wb_result_out = wb_data_mem_res_in;
            WB_PC4: wb_result_out = wb_pc_in + DATA_WIDTH'(PC_INC);
            WB_IMM: wb_result_out = wb_sign_immediate_in;
            default: wb_result_out = wb_alu_res_in;
        endcase
    end

    // Read port 1: x0 is hardwired zero, a matching commit is forwarded.
    always_comb begin
        rs1_data_out = raw1;
        if (rs1_addr_in == '0) begin
            rs1_data_out = '0;
        end else if (commit && (rs1_addr_in == wb_rd_in)) begin
            rs1_data_out = wb_result_out;
        end
    end

    // Read port 2: identical policy so both ports agree on the same address.
    always_comb begin
        rs2_data_out = raw2;
        if (rs2_addr_in == '0) begin
            rs2_data_out = '0;
        end else if (commit && (rs2_addr_in == wb_rd_in)) begin
            rs2_data_out = wb_result_out;
        end
    end

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (commit),
        .wr_addr  (wb_rd_in[AW-1:0]),
        .wr_data  (wb_result_out),
        .rd_addr1 (rs1_addr_in[AW-1:0]),
        .rd_addr2 (rs2_addr_in[AW-1:0]),
        .rd_data1 (raw1),
        .rd_data2 (raw2),
        .a0       (a0_out)
    );

endmodule
